// File: rtl/gpr_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wr_arb
// Brief    : GPR write-port arbiter. Write Back has priority, and LU results
//            drain from a small FIFO. Define GPR_ARB_STARVE_GUARD_EN to enable
//            the LU starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wr_arb #(
  parameter int XLEN       = 32,
  parameter int GPR_ASZ    = 5,
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               cpu_halt,
  input  logic               wb_valid,
  output logic               wb_rdy,
  input  logic               wb_Rd_wr,
  input  logic [GPR_ASZ-1:0] wb_Rd_addr,
  input  logic [XLEN-1:0]    wb_Rd_data,
  input  logic               lu_valid,
  output logic               lu_rdy,
  input  logic [GPR_ASZ-1:0] lu_Rd_addr,
  input  logic [XLEN-1:0]    lu_Rd_data,
  output logic               lu_pend,
  output logic               gpr_Rd_wr,
  output logic [GPR_ASZ-1:0] gpr_Rd_addr,
  output logic [XLEN-1:0]    gpr_Rd_data
);

  localparam int PTR_W = $clog2(LU_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_lu_depth = CNT_W'(LU_DEPTH);

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_PEND  = 2'd1;
`ifdef GPR_ARB_STARVE_GUARD_EN
  localparam logic [1:0] ARB_FORCE = 2'd2;
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [SW-1:0] c_starve_last = SW'(STARVE_MAX - 1);

  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_nxt;
`endif

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [GPR_ASZ-1:0] r_fifo_addr [LU_DEPTH];
  logic [XLEN-1:0]    r_fifo_data [LU_DEPTH];

  logic               w_wb_use;
  logic               w_push;
  logic               w_pop;
  logic               w_pop_wr;
  logic [GPR_ASZ-1:0] w_head_addr;
  logic [XLEN-1:0]    w_head_data;

  assign w_wb_use    = wb_valid & wb_rdy & wb_Rd_wr & (wb_Rd_addr != '0);
  assign w_push      = lu_valid & lu_rdy;
  assign w_pop       = (r_count != '0) & ~w_wb_use;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  // Entries aimed at x0 still drain but never reach the register file.
  assign w_pop_wr    = w_pop & (w_head_addr != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= lu_Rd_addr;
      r_fifo_data[r_wr_ptr] <= lu_Rd_data;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      gpr_Rd_wr   <= 1'b0;
      gpr_Rd_addr <= '0;
      gpr_Rd_data <= '0;
    end else begin
      gpr_Rd_wr <= w_wb_use | w_pop_wr;
      if (w_wb_use) begin
        gpr_Rd_addr <= wb_Rd_addr;
        gpr_Rd_data <= wb_Rd_data;
      end else if (w_pop_wr) begin
        gpr_Rd_addr <= w_head_addr;
        gpr_Rd_data <= w_head_data;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state  <= ARB_IDLE;
`ifdef GPR_ARB_STARVE_GUARD_EN
      r_starve <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
`ifdef GPR_ARB_STARVE_GUARD_EN
      r_starve <= w_starve_nxt;
`endif
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
`ifdef GPR_ARB_STARVE_GUARD_EN
    w_starve_nxt = r_starve;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_push) w_state_nxt = ARB_PEND;
      end
      ARB_PEND: begin
        if (w_count_nxt == '0) w_state_nxt = ARB_IDLE;
`ifdef GPR_ARB_STARVE_GUARD_EN
        if (w_pop)                          w_starve_nxt = '0;
        else if (r_starve == c_starve_last) w_state_nxt  = ARB_FORCE;
        else                                w_starve_nxt = r_starve + SW'(1);
`endif
      end
`ifdef GPR_ARB_STARVE_GUARD_EN
      ARB_FORCE: begin
        w_starve_nxt = '0;
        w_state_nxt  = (w_count_nxt != '0) ? ARB_PEND : ARB_IDLE;
      end
`endif
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wb_rdy = reset_in & ~cpu_halt;
`ifdef GPR_ARB_STARVE_GUARD_EN
    if (r_state == ARB_FORCE) wb_rdy = 1'b0;
`endif
    lu_rdy  = reset_in & ~cpu_halt & (r_count < c_lu_depth);
    lu_pend = (r_count != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_gpr_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wr_arb
// Brief    : Self-checking bench for gpr_wr_arb (table vectors plus sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wr_arb;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        cpu_halt;
  logic        wb_valid;
  logic        wb_rdy;
  logic        wb_Rd_wr;
  logic [4:0]  wb_Rd_addr;
  logic [31:0] wb_Rd_data;
  logic        lu_valid;
  logic        lu_rdy;
  logic [4:0]  lu_Rd_addr;
  logic [31:0] lu_Rd_data;
  logic        lu_pend;
  logic        gpr_Rd_wr;
  logic [4:0]  gpr_Rd_addr;
  logic [31:0] gpr_Rd_data;

  always #5 clk_in = ~clk_in;

  gpr_wr_arb #(
    .XLEN       (32),
    .GPR_ASZ    (5),
    .LU_DEPTH   (2),
    .STARVE_MAX (8)
  ) u_dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .cpu_halt    (cpu_halt),
    .wb_valid    (wb_valid),
    .wb_rdy      (wb_rdy),
    .wb_Rd_wr    (wb_Rd_wr),
    .wb_Rd_addr  (wb_Rd_addr),
    .wb_Rd_data  (wb_Rd_data),
    .lu_valid    (lu_valid),
    .lu_rdy      (lu_rdy),
    .lu_Rd_addr  (lu_Rd_addr),
    .lu_Rd_data  (lu_Rd_data),
    .lu_pend     (lu_pend),
    .gpr_Rd_wr   (gpr_Rd_wr),
    .gpr_Rd_addr (gpr_Rd_addr),
    .gpr_Rd_data (gpr_Rd_data)
  );

`ifdef GPR_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic        halt;
    logic        wbv;
    logic        wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        luv;
    logic [4:0]  lua;
    logic [31:0] lud;
    logic        e_wbrdy;
    logic        e_lurdy;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_pend;
  } vec_t;

  vec_t vecs [13];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_idle();
    cpu_halt   = 1'b0;
    wb_valid   = 1'b0;
    wb_Rd_wr   = 1'b0;
    wb_Rd_addr = 5'd0;
    wb_Rd_data = 32'd0;
    lu_valid   = 1'b0;
    lu_Rd_addr = 5'd0;
    lu_Rd_data = 32'd0;
  endtask

  initial begin
    reset_in = 1'b0;
    drive_idle();

    //          halt  wbv   wbw   wba    wbd             luv   lua    lud             wbrdy lurdy wr    addr   data            pend
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 5'd5,  32'h1234_5678, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'hA5,        1'b1, 1'b1, 1'b0, 5'd5,  32'h1234_5678, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 5'd7,  32'hA5,        1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'd3,  32'h33,        1'b1, 5'd9,  32'h99,        1'b1, 1'b1, 1'b1, 5'd3,  32'h33,        1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd4,  32'h44,        1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 5'd9,  32'h99,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'd6,  32'h66,        1'b1, 5'd0,  32'hDEAD,      1'b1, 1'b1, 1'b1, 5'd6,  32'h66,        1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'd0,  32'hBAD,       1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 5'd6,  32'h66,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd11, 32'hB,         1'b1, 5'd10, 32'hA,         1'b1, 1'b1, 1'b1, 5'd11, 32'hB,         1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd13, 32'hD,         1'b1, 5'd12, 32'hC,         1'b1, 1'b1, 1'b1, 5'd13, 32'hD,         1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'd15, 32'hF,         1'b1, 5'd14, 32'hE,         1'b1, 1'b0, 1'b1, 5'd15, 32'hF,         1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 5'd16, 32'h10,        1'b1, 5'd17, 32'h11,        1'b0, 1'b0, 1'b1, 5'd10, 32'hA,         1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 5'd16, 32'h10,        1'b1, 5'd17, 32'h11,        1'b0, 1'b0, 1'b1, 5'd12, 32'hC,         1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 5'd12, 32'hC,         1'b0};

    repeat (2) @(negedge clk_in);
    check("rst_gpr_wr",   32'(gpr_Rd_wr),   32'd0);
    check("rst_gpr_addr", 32'(gpr_Rd_addr), 32'd0);
    check("rst_gpr_data", gpr_Rd_data,      32'd0);
    check("rst_wb_rdy",   32'(wb_rdy),      32'd0);
    check("rst_lu_rdy",   32'(lu_rdy),      32'd0);
    check("rst_lu_pend",  32'(lu_pend),     32'd0);
    reset_in = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cpu_halt   = vecs[i].halt;
      wb_valid   = vecs[i].wbv;
      wb_Rd_wr   = vecs[i].wbw;
      wb_Rd_addr = vecs[i].wba;
      wb_Rd_data = vecs[i].wbd;
      lu_valid   = vecs[i].luv;
      lu_Rd_addr = vecs[i].lua;
      lu_Rd_data = vecs[i].lud;
      #1;
      check($sformatf("v%0d_wb_rdy", i), 32'(wb_rdy), 32'(vecs[i].e_wbrdy));
      check($sformatf("v%0d_lu_rdy", i), 32'(lu_rdy), 32'(vecs[i].e_lurdy));
      @(posedge clk_in);
      #1;
      check($sformatf("v%0d_gpr_wr", i),   32'(gpr_Rd_wr),   32'(vecs[i].e_wr));
      check($sformatf("v%0d_gpr_addr", i), 32'(gpr_Rd_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_gpr_data", i), gpr_Rd_data,      vecs[i].e_data);
      check($sformatf("v%0d_lu_pend", i),  32'(lu_pend),     32'(vecs[i].e_pend));
      @(negedge clk_in);
    end

    // Starvation: two LU entries queued while WB writes x1 every cycle.
    for (int c = 0; c < 13; c++) begin
      bit force_cyc;
      force_cyc  = GUARD && (c == 9);
      cpu_halt   = 1'b0;
      wb_valid   = 1'b1;
      wb_Rd_wr   = 1'b1;
      wb_Rd_addr = 5'd1;
      wb_Rd_data = 32'(c);
      lu_valid   = (c < 3);
      lu_Rd_addr = 5'(7 + c);
      lu_Rd_data = 32'(32'h77 + 32'h11 * c);
      #1;
      check($sformatf("starve%0d_wb_rdy", c), 32'(wb_rdy), 32'(!force_cyc));
      if (c == 2) check("starve_lu_rdy_full", 32'(lu_rdy), 32'd0);
      @(posedge clk_in);
      #1;
      check($sformatf("starve%0d_gpr_wr", c),   32'(gpr_Rd_wr),   32'd1);
      check($sformatf("starve%0d_gpr_addr", c), 32'(gpr_Rd_addr), force_cyc ? 32'd7 : 32'd1);
      check($sformatf("starve%0d_gpr_data", c), gpr_Rd_data,      force_cyc ? 32'h77 : 32'(c));
      check($sformatf("starve%0d_lu_pend", c),  32'(lu_pend),     32'd1);
      @(negedge clk_in);
    end
    drive_idle();
`ifdef GPR_ARB_STARVE_GUARD_EN
    @(posedge clk_in);
    #1;
    check("drain_x8_wr",   32'(gpr_Rd_wr),   32'd1);
    check("drain_x8_addr", 32'(gpr_Rd_addr), 32'd8);
    check("drain_x8_data", gpr_Rd_data,      32'h88);
    check("drain_x8_pend", 32'(lu_pend),     32'd0);
    @(negedge clk_in);
`else
    @(posedge clk_in);
    #1;
    check("drain_x7_wr",   32'(gpr_Rd_wr),   32'd1);
    check("drain_x7_addr", 32'(gpr_Rd_addr), 32'd7);
    check("drain_x7_data", gpr_Rd_data,      32'h77);
    check("drain_x7_pend", 32'(lu_pend),     32'd1);
    @(negedge clk_in);
    @(posedge clk_in);
    #1;
    check("drain_x8_wr",   32'(gpr_Rd_wr),   32'd1);
    check("drain_x8_addr", 32'(gpr_Rd_addr), 32'd8);
    check("drain_x8_data", gpr_Rd_data,      32'h88);
    check("drain_x8_pend", 32'(lu_pend),     32'd0);
    @(negedge clk_in);
`endif

    // Asynchronous reset mid-clock with the FIFO full.
    for (int c = 0; c < 3; c++) begin
      wb_valid   = 1'b1;
      wb_Rd_wr   = 1'b1;
      wb_Rd_addr = 5'd2;
      wb_Rd_data = 32'(c + 2);
      lu_valid   = (c < 2);
      lu_Rd_addr = 5'(20 + c);
      lu_Rd_data = 32'(32'h200 + c);
      @(posedge clk_in);
      if (c < 2) @(negedge clk_in);
    end
    #1;
    check("pre_rst_lu_pend", 32'(lu_pend),   32'd1);
    check("pre_rst_gpr_wr",  32'(gpr_Rd_wr), 32'd1);
    #1;
    reset_in = 1'b0;
    #1;
    check("async_rst_gpr_wr",   32'(gpr_Rd_wr),   32'd0);
    check("async_rst_gpr_addr", 32'(gpr_Rd_addr), 32'd0);
    check("async_rst_lu_pend",  32'(lu_pend),     32'd0);
    check("async_rst_wb_rdy",   32'(wb_rdy),      32'd0);
    check("async_rst_lu_rdy",   32'(lu_rdy),      32'd0);
    drive_idle();
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_in);
      #1;
      check($sformatf("post_rst%0d_gpr_wr", c),  32'(gpr_Rd_wr), 32'd0);
      check($sformatf("post_rst%0d_lu_pend", c), 32'(lu_pend),   32'd0);
      @(negedge clk_in);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_wr_arb.md
Name: gpr_wr_arb

Overview:
- Arbitrates the single GPR write port between two requesters: the Write Back stage and a long-latency unit (LU) return path, such as a divider or late load.
- Write Back is the primary requester and never waits unless the starvation guard fires.
- LU results queue in a small FIFO and drain into the write port whenever Write Back does not use it.
- Sits between the WB stage / LU and the register file write port.

Parameters:
- XLEN, 32, data width of GPR write data.
- GPR_ASZ, 5, GPR address width.
- LU_DEPTH, 2, LU result FIFO depth; power of two, at least 2.
- STARVE_MAX, 8, cycles a non-empty FIFO may go without a pop before Write Back is stalled.

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  asynchronous, active-low reset.
- cpu_halt  input  1  1 = accept no new requests from either side.
- wb_valid  input  1  WB request valid.
- wb_rdy  output  1  arbiter accepts the WB request.
- wb_Rd_wr  input  1  WB request writes a GPR.
- wb_Rd_addr  input  GPR_ASZ  WB destination register.
- wb_Rd_data  input  XLEN  WB write data.
- lu_valid  input  1  LU result valid.
- lu_rdy  output  1  FIFO accepts the LU result.
- lu_Rd_addr  input  GPR_ASZ  LU destination register.
- lu_Rd_data  input  XLEN  LU result data.
- lu_pend  output  1  FIFO non-empty; decode uses it for hazard stalls.
- gpr_Rd_wr  output  1  register file write enable.
- gpr_Rd_addr  output  GPR_ASZ  register file write address.
- gpr_Rd_data  output  XLEN  register file write data.

Behaviour:
- Reset (reset_in=0, asynchronous):
  - FIFO emptied: count=0, read/write pointers=0.
  - FSM to ARB_IDLE; starve counter=0.
  - gpr_Rd_wr=0, gpr_Rd_addr=0, gpr_Rd_data=0.
  - wb_rdy=0, lu_rdy=0, lu_pend=0.
- Reset asserted mid-operation discards queued LU results; no write is issued for them.
- Handshakes: transfer on valid & rdy.
  - wb_rdy = reset_in & !cpu_halt & (state != ARB_FORCE).
  - lu_rdy = reset_in & !cpu_halt & (count < LU_DEPTH).
  - lu_rdy is computed from the pre-pop count; there is no pass-through when full.
- wb_use (WB claims the write port) = WB transfer & wb_Rd_wr & (wb_Rd_addr != 0).
  - A WB transfer without wb_use still completes but does not claim the port.
- pop (one FIFO entry drains) = (count != 0) & !wb_use.
  - If the popped entry has Rd_addr = 0, the entry is dropped and no write is issued.
- Write-port outputs are registered, giving 1-cycle latency from the accepting edge:
  - On wb_use: gpr outputs take WB addr/data with gpr_Rd_wr=1.
  - Else on pop: gpr outputs take the FIFO head with gpr_Rd_wr=1.
  - Otherwise gpr_Rd_wr=0 and addr/data hold their previous values.
- FIFO:
  - Push and pop may occur in the same cycle; count is unchanged.
  - Pointers wrap modulo LU_DEPTH.
  - lu_pend = (count != 0), reflecting the registered count.
- FSM:
  - ARB_IDLE: count = 0. Moves to ARB_PEND when a push occurs.
  - ARB_PEND: count > 0.
    - Each cycle without a pop increments starve_cnt; any pop clears it.
    - If count becomes 0, go to ARB_IDLE.
    - If starve_cnt reaches STARVE_MAX-1 on a no-pop cycle, go to ARB_FORCE.
  - ARB_FORCE:
    - wb_rdy=0, so the pop is guaranteed this cycle.
    - starve_cnt cleared.
    - Next state is ARB_PEND if the post-pop count > 0, else ARB_IDLE.
    - Lasts exactly 1 cycle.
- cpu_halt blocks new transfers only; queued LU entries continue to drain.
- Ordering between WB and LU results to the same register is not checked here; decode prevents it using lu_pend.

Optional Feature:
- Macro GPR_ARB_STARVE_GUARD_EN.
- When defined: ARB_FORCE and starve_cnt exist exactly as described above.
- When undefined:
  - No starve counter.
  - FSM has only ARB_IDLE and ARB_PEND.
  - wb_rdy = reset_in & !cpu_halt.
  - The LU drains only on cycles without wb_use.

Test Plan:
- Reset, then a WB transfer with Rd_addr=5, data=0x1234_5678, Rd_wr=1 -> next cycle gpr_Rd_wr=1, addr=5, data=0x12345678; lu_pend=0.
- LU pushes addr=7, data=0xA5 while WB is idle -> lu_pend=1 for 1 cycle; next edge gpr writes x7=0xA5; lu_pend returns to 0.
- Two LU pushes, then a third with WB writing every cycle -> lu_rdy=0 on the third.
  - With the guard: after 8 cycles wb_rdy=0 for exactly 1 cycle and x7 is written.
  - Without the guard: the queue holds until WB idles.
- WB request with Rd_wr=0 in the same cycle as a queued LU entry -> WB accepted and the LU entry written that cycle; a WB write to x0 likewise lets the LU pop, and no write to x0 is issued.
- cpu_halt=1 with 2 queued entries -> wb_rdy=0 and lu_rdy=0; both entries are written on the next 2 cycles.
- Assert reset_in=0 asynchronously mid-clock with the FIFO full -> gpr_Rd_wr=0 and lu_pend=0 immediately; no queued writes appear after release.
